basilisk_writeback: RTL and testbench

Writeback stage of the Basilisk vector FPU. It sits directly downstream of the functional units (add, mult/macc, divide, sqrt, convert). It round-robin arbitrates their `basilisk_writeback_result_t` streams onto the single vector-register-file write port. It also tracks which unit-width slices (offsets) of each destination vector register have arrived, and pulses a completion event when a register is fully written so the issue scoreboard can release it.

---
 rtl/basilisk_writeback.sv | 136 +++++++++++++
 tb/tb_basilisk_writeback.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/basilisk_writeback.sv
// Basilisk vector FPU writeback stage.
// Round-robin arbitration of functional-unit result streams onto the single
// vector-register-file write port, with per-register slice tracking that
// pulses a completion event once every slice of a register has arrived.
//
// Handshake: a unit transfers a result in any cycle where unit_valid[i] and
// unit_ready[i] are both high; a unit holds valid and data stable until it
// sees ready, and ready depends only on the valids and the round-robin
// pointer (the write port never stalls).

package basilisk_pkg;
    localparam int BASILISK_VECTOR_WIDTH      = 128;
    localparam int BASILISK_VECTOR_UNIT_WIDTH = 32;
    localparam int BASILISK_OFFSET_ADDR_WIDTH =
        $clog2(BASILISK_VECTOR_WIDTH / BASILISK_VECTOR_UNIT_WIDTH);

    typedef struct packed {
        logic [4:0]                            dest_reg_addr;
        logic [BASILISK_OFFSET_ADDR_WIDTH-1:0] dest_offset_addr;
        logic [31:0]                           result;
    } basilisk_writeback_result_t;
endpackage

module basilisk_writeback
    import basilisk_pkg::*;
#(
    parameter int NUM_UNITS = 5,
    parameter int OFFSETS   = BASILISK_VECTOR_WIDTH / BASILISK_VECTOR_UNIT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_UNITS-1:0]                  unit_valid,
    output logic [NUM_UNITS-1:0]                  unit_ready,
    input  basilisk_writeback_result_t [NUM_UNITS-1:0] unit_data,
    output logic                                  wb_valid,
    output logic [4:0]                            wb_reg_addr,
    output logic [BASILISK_OFFSET_ADDR_WIDTH-1:0] wb_offset_addr,
    output logic [31:0]                           wb_value,
    output logic                                  done_valid,
    output logic [4:0]                            done_reg_addr,
    output logic                                  dup_error
);

    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           ptr_next;
    logic [PTR_W-1:0]           grant_idx;
    logic [PTR_W-1:0]           idx_p;
    logic [NUM_UNITS-1:0]       grant;
    logic                       found;
    int                         idx;

    logic [OFFSETS-1:0]         mask [32];
    basilisk_writeback_result_t sel;
    logic [OFFSETS-1:0]         slice_bit;
    logic [OFFSETS-1:0]         cur_mask;
    logic [OFFSETS-1:0]         new_mask;
    logic                       reg_full;
    logic                       slice_dup;

    // Round-robin search starting at rr_ptr; no grant while reset is held.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_p     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_UNITS) begin
                idx = idx - NUM_UNITS;
            end
            idx_p = PTR_W'(idx);
            if (!found && unit_valid[idx_p]) begin
                found        = 1'b1;
                grant[idx_p] = 1'b1;
                grant_idx    = idx_p;
            end
        end
        if (!rst) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign unit_ready = grant;

    // Slice bookkeeping for the granted result; out-of-range offsets match no bit.
    always_comb begin
        sel       = unit_data[grant_idx];
        slice_bit = '0;
        for (int j = 0; j < OFFSETS; j++) begin
            slice_bit[j] = (sel.dest_offset_addr == BASILISK_OFFSET_ADDR_WIDTH'(j));
        end
        cur_mask  = mask[sel.dest_reg_addr];
        new_mask  = cur_mask | slice_bit;
        reg_full  = &new_mask;
        slice_dup = |(cur_mask & slice_bit);
        ptr_next  = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Pointer, write register, completion pulse, masks and sticky duplicate flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr         <= '0;
            wb_valid       <= 1'b0;
            wb_reg_addr    <= '0;
            wb_offset_addr <= '0;
            wb_value       <= '0;
            done_valid     <= 1'b0;
            done_reg_addr  <= '0;
            dup_error      <= 1'b0;
            for (int r = 0; r < 32; r++) begin
                mask[r] <= '0;
            end
        end else begin
            wb_valid   <= found;
            done_valid <= found && reg_full;
            if (found) begin
                rr_ptr         <= ptr_next;
                wb_reg_addr    <= sel.dest_reg_addr;
                wb_offset_addr <= sel.dest_offset_addr;
                wb_value       <= sel.result;
                mask[sel.dest_reg_addr] <= reg_full ? '0 : new_mask;
                if (reg_full) begin
                    done_reg_addr <= sel.dest_reg_addr;
                end
                if (slice_dup) begin
                    dup_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_basilisk_writeback.sv
// Bench for basilisk_writeback: drives result streams, keeps a behavioural
// model of the arbiter and slice masks, and scoreboards every write.
module tb_basilisk_writeback;
    import basilisk_pkg::*;

    localparam int NU  = 5;
    localparam int OFF = 4;
    localparam int W   = 40; // {done, reg[4:0], off[1:0], value[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NU-1:0]                          unit_valid;
    logic [NU-1:0]                          unit_ready;
    basilisk_writeback_result_t [NU-1:0]    unit_data;
    logic                                   wb_valid;
    logic [4:0]                             wb_reg_addr;
    logic [BASILISK_OFFSET_ADDR_WIDTH-1:0]  wb_offset_addr;
    logic [31:0]                            wb_value;
    logic                                   done_valid;
    logic [4:0]                             done_reg_addr;
    logic                                   dup_error;

    basilisk_writeback #(.NUM_UNITS(NU), .OFFSETS(OFF)) dut (
        .clk(clk), .rst(rst),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_data(unit_data),
        .wb_valid(wb_valid), .wb_reg_addr(wb_reg_addr),
        .wb_offset_addr(wb_offset_addr), .wb_value(wb_value),
        .done_valid(done_valid), .done_reg_addr(done_reg_addr),
        .dup_error(dup_error)
    );

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0]   exp_q[$];
    int             n_vec = 0;
    int             n_err = 0;
    int             m_rr;
    logic [OFF-1:0] m_mask [32];
    logic           m_dup;
    logic [4:0]     m_wreg;
    logic [1:0]     m_woff;
    logic [31:0]    m_wval;
    logic [4:0]     m_dreg;
    int             done_cnt [32];
    int             last_grant;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr   = 0;
        m_dup  = 1'b0;
        m_wreg = '0;
        m_woff = '0;
        m_wval = '0;
        m_dreg = '0;
        for (int r = 0; r < 32; r++) m_mask[r] = '0;
        exp_q.delete();
    endtask

    task automatic clear_done_cnt();
        for (int r = 0; r < 32; r++) done_cnt[r] = 0;
    endtask

    function automatic int model_grant(input logic [NU-1:0] v);
        int i;
        for (int k = 0; k < NU; k++) begin
            i = (m_rr + k) % NU;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_unit(input int u, input logic [4:0] r, input logic [1:0] o,
                            input logic [31:0] val);
        unit_data[u].dest_reg_addr    = r;
        unit_data[u].dest_offset_addr = o;
        unit_data[u].result           = val;
    endtask

    // One clock: present valids, check ready, predict, then check outputs.
    task automatic do_cycle(input logic [NU-1:0] v);
        int             g;
        logic [NU-1:0]  eg;
        logic [W-1:0]   e;
        logic [OFF-1:0] nm;
        logic           dn;
        basilisk_writeback_result_t d;
        unit_valid = v;
        #1;
        g  = model_grant(v);
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check_eq("unit_ready", 64'(unit_ready), 64'(eg));
        last_grant = g;
        if (g >= 0) begin
            d  = unit_data[g];
            nm = m_mask[d.dest_reg_addr] | (OFF'(1) << d.dest_offset_addr);
            if (m_mask[d.dest_reg_addr][d.dest_offset_addr]) m_dup = 1'b1;
            dn = &nm;
            m_mask[d.dest_reg_addr] = dn ? '0 : nm;
            m_rr = (g + 1) % NU;
            exp_q.push_back({dn, d.dest_reg_addr, d.dest_offset_addr, d.result});
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            e = exp_q.pop_front();
            check_eq("wb_valid", 64'(wb_valid), 64'd1);
            check_eq("wb_reg_addr", 64'(wb_reg_addr), 64'(e[38:34]));
            check_eq("wb_offset_addr", 64'(wb_offset_addr), 64'(e[33:32]));
            check_eq("wb_value", 64'(wb_value), 64'(e[31:0]));
            check_eq("done_valid", 64'(done_valid), 64'(e[39]));
            if (e[39]) begin
                m_dreg = e[38:34];
            end
            m_wreg = e[38:34];
            m_woff = e[33:32];
            m_wval = e[31:0];
        end else begin
            check_eq("idle_wb_valid", 64'(wb_valid), 64'd0);
            check_eq("idle_done_valid", 64'(done_valid), 64'd0);
            check_eq("idle_wb_value", 64'(wb_value), 64'(m_wval));
            check_eq("idle_wb_reg_addr", 64'(wb_reg_addr), 64'(m_wreg));
            check_eq("idle_wb_offset_addr", 64'(wb_offset_addr), 64'(m_woff));
        end
        check_eq("done_reg_addr", 64'(done_reg_addr), 64'(m_dreg));
        check_eq("dup_error", 64'(dup_error), 64'(m_dup));
        if (done_valid) done_cnt[done_reg_addr]++;
    endtask

    // Reset pulse of one cycle, with outputs checked while held.
    task automatic reset_pulse(input logic [NU-1:0] v);
        unit_valid = v;
        rst = 1'b0;
        #1;
        check_eq("rst_unit_ready", 64'(unit_ready), 64'd0);
        check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_eq("rst_done_valid", 64'(done_valid), 64'd0);
        check_eq("rst_dup_error", 64'(dup_error), 64'd0);
        check_eq("rst_wb_reg_addr", 64'(wb_reg_addr), 64'd0);
        check_eq("rst_wb_offset_addr", 64'(wb_offset_addr), 64'd0);
        check_eq("rst_wb_value", 64'(wb_value), 64'd0);
        check_eq("rst_done_reg_addr", 64'(done_reg_addr), 64'd0);
        check_eq("rst_rr_ptr", 64'(dut.rr_ptr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    int             exp_order [6] = '{0, 1, 2, 3, 4, 0};
    int             grants_u [NU];
    logic [31:0]    single_vals [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    int             il_unit [8] = '{0, 2, 2, 0, 0, 2, 0, 2};
    int             il_off  [8] = '{3, 1, 3, 0, 2, 0, 1, 2};
    int             dup_off [5] = '{1, 1, 0, 2, 3};
    logic [NU-1:0]  rv;

    initial begin
        unit_valid = '0;
        for (int u = 0; u < NU; u++) set_unit(u, 5'd0, 2'd0, 32'd0);
        model_reset();
        clear_done_cnt();
        repeat (2) @(posedge clk);
        #1;
        reset_pulse('1);

        // Single unit: reg 7, offsets 0..3.
        clear_done_cnt();
        for (int i = 0; i < 4; i++) begin
            set_unit(1, 5'd7, 2'(i), single_vals[i]);
            do_cycle(5'b00010);
            check_eq("single_done", 64'(done_valid), 64'(i == 3));
        end
        check_eq("single_done_cnt7", 64'(done_cnt[7]), 64'd1);

        // All units contending from rr_ptr = 0.
        reset_pulse('0);
        for (int u = 0; u < NU; u++) begin
            grants_u[u] = 0;
            set_unit(u, 5'(10 + u), 2'd0, 32'hA000_0000 + 32'(u));
        end
        for (int i = 0; i < 6; i++) begin
            do_cycle('1);
            check_eq("rr_order", 64'(last_grant), 64'(exp_order[i]));
            if (last_grant >= 0) begin
                grants_u[last_grant]++;
                set_unit(last_grant, 5'(10 + last_grant), 2'(grants_u[last_grant]),
                         32'hB000_0000 + 32'(i));
            end
        end

        // Interleaved registers 2 (unit 0) and 9 (unit 2).
        clear_done_cnt();
        for (int i = 0; i < 8; i++) begin
            if (il_unit[i] == 0) set_unit(0, 5'd2, 2'(il_off[i]), 32'hC000_0000 + 32'(i));
            else                 set_unit(2, 5'd9, 2'(il_off[i]), 32'hD000_0000 + 32'(i));
            do_cycle(NU'(1) << il_unit[i]);
        end
        check_eq("il_done_cnt2", 64'(done_cnt[2]), 64'd1);
        check_eq("il_done_cnt9", 64'(done_cnt[9]), 64'd1);

        // Duplicate slice on reg 4.
        clear_done_cnt();
        for (int i = 0; i < 5; i++) begin
            set_unit(3, 5'd4, 2'(dup_off[i]), 32'hE000_0000 + 32'(i));
            do_cycle(5'b01000);
            check_eq("dup_seq", 64'(dup_error), 64'(i >= 1));
        end
        check_eq("dup_done_cnt4", 64'(done_cnt[4]), 64'd1);

        // Reset mid-register on reg 5.
        for (int i = 0; i < 2; i++) begin
            set_unit(4, 5'd5, 2'(i), 32'hF000_0000 + 32'(i));
            do_cycle(5'b10000);
        end
        reset_pulse(5'b10000);
        clear_done_cnt();
        for (int i = 2; i < 4; i++) begin
            set_unit(4, 5'd5, 2'(i), 32'hF100_0000 + 32'(i));
            do_cycle(5'b10000);
        end
        check_eq("rstmid_no_done", 64'(done_cnt[5]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            set_unit(4, 5'd5, 2'(i), 32'hF200_0000 + 32'(i));
            do_cycle(5'b10000);
        end
        check_eq("rstmid_done_cnt5", 64'(done_cnt[5]), 64'd1);

        // Idle cycles.
        for (int i = 0; i < 3; i++) begin
            do_cycle('0);
            check_eq("idle_rr_ptr", 64'(dut.rr_ptr), 64'(m_rr));
        end

        // Random traffic; a unit keeps valid and data until granted.
        rv = '0;
        for (int i = 0; i < 60; i++) begin
            for (int u = 0; u < NU; u++) begin
                if (!rv[u] || last_grant == u) begin
                    rv[u] = 1'($urandom_range(0, 1));
                    set_unit(u, 5'($urandom_range(16, 19)), 2'($urandom_range(0, 3)), $urandom);
                end
            end
            do_cycle(rv);
        end
        do_cycle('0);

        // ---------------- final report ----------------
        check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
